// File: rtl/ekf_stage_sched_if.sv
// Purpose : handshake bundle between the EKF stage scheduler and its environment
//           (frame/observation source, RSA array, nonlinear unit).
// Latency : n/a (wires only).
// Backpressure: every transfer is a val/rdy or req/ack pair; see ekf_stage_sched.
// Ports (modports):
//   master - scheduler side: drives rdy for frames/observations, stage and
//            nonlinear-result strobes, nl_req, l_k, landmark_num, status pulses.
//   slave  - environment side: the mirror image of master.
interface ekf_stage_sched_if #(
  parameter int ROW_LEN = 10,
  parameter int OBS_DW  = 4
);
  // frame command
  logic               frame_val;
  logic               frame_rdy;
  logic [OBS_DW-1:0]  obs_num;
  // per-observation command
  logic               obs_val;
  logic               obs_rdy;
  logic               obs_new;
  logic [ROW_LEN-1:0] obs_id;
  // stage issue to RSA (one-hot PRD/NEW/UPD)
  logic [2:0]         stage_val;
  logic [2:0]         stage_rdy;
  // nonlinear result exchange with RSA (one-hot per stage)
  logic [2:0]         nonlinear_m_val;
  logic [2:0]         nonlinear_m_rdy;
  logic [2:0]         nonlinear_s_val;
  logic [2:0]         nonlinear_s_rdy;
  // nonlinear unit start/done
  logic               nl_req;
  logic               nl_ack;
  // status
  logic [ROW_LEN-1:0] l_k;
  logic [ROW_LEN-1:0] landmark_num;
  logic               frame_done;
  logic               err_full;
  logic               err_id;

  modport master (
    input  frame_val, obs_num, obs_val, obs_new, obs_id,
    input  stage_rdy, nonlinear_m_val, nonlinear_m_rdy, nl_ack,
    output frame_rdy, obs_rdy, stage_val, nonlinear_s_val, nonlinear_s_rdy,
    output nl_req, l_k, landmark_num, frame_done, err_full, err_id
  );

  modport slave (
    output frame_val, obs_num, obs_val, obs_new, obs_id,
    output stage_rdy, nonlinear_m_val, nonlinear_m_rdy, nl_ack,
    input  frame_rdy, obs_rdy, stage_val, nonlinear_s_val, nonlinear_s_rdy,
    input  nl_req, l_k, landmark_num, frame_done, err_full, err_id
  );
endinterface

// File: rtl/ekf_stage_sched.sv
// Purpose : sequences EKF-SLAM stages (predict, new-landmark, update) for each
//           frame, coordinating the RSA array and the nonlinear unit.
// Latency : stage_val rises the cycle after a frame/observation is accepted;
//           every FSM output is registered (one cycle after the causing edge).
// Backpressure: each step waits indefinitely on its own handshake input
//           (stage_rdy, nonlinear_m_val, nl_ack, nonlinear_m_rdy, obs_val);
//           frame_rdy / obs_rdy are only high in IDLE / OBS.
// Ports:
//   clk     - single clock, rising edge.
//   sys_rst - synchronous active-high reset.
//   bus     - ekf_stage_sched_if.master: all frame, observation, stage,
//             nonlinear, nl_req/nl_ack and status signals.
module ekf_stage_sched #(
  parameter int ROW_LEN = 10,
  parameter int LM_MAX  = 64,
  parameter int OBS_DW  = 4
) (
  input  logic                clk,
  input  logic                sys_rst,
  ekf_stage_sched_if.master   bus
);

  localparam logic [2:0] ST_PRD = 3'b001;
  localparam logic [2:0] ST_NEW = 3'b010;
  localparam logic [2:0] ST_UPD = 3'b100;

  localparam logic [ROW_LEN-1:0] LM_MAX_C = ROW_LEN'(LM_MAX);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_M,
    NL_WAIT,
    SVAL,
    FIN,
    NEXT,
    OBS
  } state_t;

  state_t             state_q;
  logic [2:0]         cur_stage_q;
  logic [OBS_DW-1:0]  obs_left_q;
  logic [ROW_LEN-1:0] l_k_q;
  logic [ROW_LEN-1:0] lm_num_q;

  // registered outputs
  logic               frame_rdy_q;
  logic               obs_rdy_q;
  logic [2:0]         stage_val_q;
  logic [2:0]         nl_s_val_q;
  logic [2:0]         nl_s_rdy_q;
  logic               nl_req_q;
  logic               frame_done_q;
  logic               err_full_q;
  logic               err_id_q;

  // next-state helpers
  logic [OBS_DW-1:0]  obs_left_d;
  logic [ROW_LEN-1:0] lm_num_d;
  logic               lm_full;
  logic               accept_new;
  logic               accept_upd;

  always_comb begin
    obs_left_d = obs_left_q - OBS_DW'(1);
    lm_full    = (lm_num_q >= LM_MAX_C);
    // landmark count saturates at map capacity
    lm_num_d   = lm_full ? lm_num_q : lm_num_q + ROW_LEN'(1);
    accept_new = bus.obs_new && !lm_full;
    accept_upd = !bus.obs_new && (bus.obs_id < lm_num_q);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      // abandons any in-flight stage: no completion pulses, no count update
      state_q      <= IDLE;
      cur_stage_q  <= 3'b000;
      obs_left_q   <= '0;
      l_k_q        <= '0;
      lm_num_q     <= '0;
      frame_rdy_q  <= 1'b1;
      obs_rdy_q    <= 1'b0;
      stage_val_q  <= 3'b000;
      nl_s_val_q   <= 3'b000;
      nl_s_rdy_q   <= 3'b000;
      nl_req_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_full_q   <= 1'b0;
      err_id_q     <= 1'b0;
    end else begin
      // single-cycle pulses default low
      nl_req_q     <= 1'b0;
      frame_done_q <= 1'b0;
      err_full_q   <= 1'b0;
      err_id_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.frame_val) begin
            obs_left_q  <= bus.obs_num;
            cur_stage_q <= ST_PRD;
            stage_val_q <= ST_PRD;
            frame_rdy_q <= 1'b0;
            state_q     <= ISSUE;
          end
        end

        ISSUE: begin
          // only the bit of the stage being issued counts as acceptance
          if ((bus.stage_rdy & cur_stage_q) != 3'b000) begin
            stage_val_q <= 3'b000;
            state_q     <= WAIT_M;
          end
        end

        WAIT_M: begin
          if ((bus.nonlinear_m_val & cur_stage_q) != 3'b000) begin
            nl_req_q <= 1'b1;
            state_q  <= NL_WAIT;
          end
        end

        NL_WAIT: begin
          if (bus.nl_ack) begin
            nl_s_val_q <= cur_stage_q;
            state_q    <= SVAL;
          end
        end

        SVAL: begin
          nl_s_val_q <= 3'b000;
          state_q    <= FIN;
        end

        FIN: begin
          if ((bus.nonlinear_m_rdy & cur_stage_q) != 3'b000) begin
            nl_s_rdy_q <= cur_stage_q;
            state_q    <= NEXT;
          end
        end

        NEXT: begin
          nl_s_rdy_q <= 3'b000;
          if (cur_stage_q == ST_NEW) begin
            lm_num_q <= lm_num_d;
          end
          if (obs_left_q == '0) begin
            frame_done_q <= 1'b1;
            frame_rdy_q  <= 1'b1;
            state_q      <= IDLE;
          end else begin
            obs_rdy_q <= 1'b1;
            state_q   <= OBS;
          end
        end

        OBS: begin
          if (bus.obs_val) begin
            obs_left_q <= obs_left_d;
            if (accept_new || accept_upd) begin
              cur_stage_q <= accept_new ? ST_NEW : ST_UPD;
              stage_val_q <= accept_new ? ST_NEW : ST_UPD;
              // a new landmark takes the next free slot
              l_k_q       <= accept_new ? lm_num_q : bus.obs_id;
              obs_rdy_q   <= 1'b0;
              state_q     <= ISSUE;
            end else begin
              err_full_q <= bus.obs_new;
              err_id_q   <= !bus.obs_new;
              // rejected observation: stay for the next one or close the frame
              if (obs_left_d == '0) begin
                obs_rdy_q    <= 1'b0;
                frame_done_q <= 1'b1;
                frame_rdy_q  <= 1'b1;
                state_q      <= IDLE;
              end
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.frame_rdy       = frame_rdy_q;
  assign bus.obs_rdy         = obs_rdy_q;
  assign bus.stage_val       = stage_val_q;
  assign bus.nonlinear_s_val = nl_s_val_q;
  assign bus.nonlinear_s_rdy = nl_s_rdy_q;
  assign bus.nl_req          = nl_req_q;
  assign bus.l_k             = l_k_q;
  assign bus.landmark_num    = lm_num_q;
  assign bus.frame_done      = frame_done_q;
  assign bus.err_full        = err_full_q;
  assign bus.err_id          = err_id_q;

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Purpose : directed + randomized check of ekf_stage_sched against a frame-level
//           model (landmark count, last landmark index, accept/reject rules).
// Latency : n/a.
// Backpressure: the bench acts as RSA / nonlinear unit with random response delays.
module tb_ekf_stage_sched;
  localparam int RL = 10;
  localparam int LM = 2;
  localparam int OD = 4;

  localparam logic [2:0] PRD = 3'b001;
  localparam logic [2:0] NEW = 3'b010;
  localparam logic [2:0] UPD = 3'b100;

  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  ekf_stage_sched_if #(.ROW_LEN(RL), .OBS_DW(OD)) bus ();

  ekf_stage_sched #(.ROW_LEN(RL), .LM_MAX(LM), .OBS_DW(OD)) dut (
    .clk     (clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int nchk = 0;
  int nerr = 0;
  // reference model state
  int lm = 0;   // landmarks in the map
  int lk = 0;   // last landmark index selected

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_stage_val"}, 32'(bus.stage_val), 0);
    chk({tag, "_s_val"}, 32'(bus.nonlinear_s_val), 0);
    chk({tag, "_s_rdy"}, 32'(bus.nonlinear_s_rdy), 0);
    chk({tag, "_nl_req"}, 32'(bus.nl_req), 0);
    chk({tag, "_obs_rdy"}, 32'(bus.obs_rdy), 0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_err_full"}, 32'(bus.err_full), 0);
    chk({tag, "_err_id"}, 32'(bus.err_id), 0);
    chk({tag, "_l_k"}, 32'(bus.l_k), 0);
    chk({tag, "_landmark_num"}, 32'(bus.landmark_num), 0);
    chk({tag, "_frame_rdy"}, 32'(bus.frame_rdy), 1);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    lm = 0;
    lk = 0;
    chk_idle_outputs("reset");
  endtask

  // Bench is already at the negedge where stage_val shows the issued stage.
  // Returns at the negedge after the NEXT cycle.
  task automatic run_stage(input logic [2:0] st, input int exp_lk);
    int n;
    chk("stage_val", 32'(bus.stage_val), 32'(st));
    chk("l_k", 32'(bus.l_k), exp_lk);
    // wrong stage_rdy bits plus premature responses, all to be ignored
    n = int'($urandom_range(1, 2));
    for (int i = 0; i < n; i++) begin
      bus.stage_rdy       = 3'($urandom) & ~st;
      bus.nonlinear_m_val = st;
      bus.nl_ack          = 1'b1;
      bus.obs_val         = 1'b1;
      step();
      chk("stage_hold", 32'(bus.stage_val), 32'(st));
      chk("nl_req_early", 32'(bus.nl_req), 0);
    end
    bus.stage_rdy       = st | (3'($urandom) & ~st);
    bus.nonlinear_m_val = 3'b000;
    bus.nl_ack          = 1'b0;
    bus.obs_val         = 1'b0;
    step();
    bus.stage_rdy = 3'b000;
    chk("stage_drop", 32'(bus.stage_val), 0);
    n = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      bus.nl_ack          = 1'b1;
      bus.nonlinear_m_val = 3'($urandom) & ~st;
      step();
      chk("nl_req_wait", 32'(bus.nl_req), 0);
    end
    bus.nl_ack          = 1'b0;
    bus.nonlinear_m_val = st;
    step();
    bus.nonlinear_m_val = 3'b000;
    chk("nl_req", 32'(bus.nl_req), 1);
    step();
    chk("nl_req_pulse", 32'(bus.nl_req), 0);
    n = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      step();
      chk("s_val_wait", 32'(bus.nonlinear_s_val), 0);
    end
    bus.nl_ack = 1'b1;
    step();
    bus.nl_ack = 1'b0;
    chk("s_val", 32'(bus.nonlinear_s_val), 32'(st));
    chk("s_rdy_in_sval", 32'(bus.nonlinear_s_rdy), 0);
    chk("stage_in_sval", 32'(bus.stage_val), 0);
    step();
    chk("s_val_pulse", 32'(bus.nonlinear_s_val), 0);
    n = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) begin
      bus.nonlinear_m_rdy = 3'($urandom) & ~st;
      step();
      chk("s_rdy_wait", 32'(bus.nonlinear_s_rdy), 0);
    end
    bus.nonlinear_m_rdy = st;
    step();
    bus.nonlinear_m_rdy = 3'b000;
    chk("s_rdy", 32'(bus.nonlinear_s_rdy), 32'(st));
    chk("s_val_in_next", 32'(bus.nonlinear_s_val), 0);
    chk("l_k_hold", 32'(bus.l_k), exp_lk);
    step();
    chk("s_rdy_pulse", 32'(bus.nonlinear_s_rdy), 0);
  endtask

  task automatic end_of_item(input int left);
    if (left == 0) begin
      chk("frame_done", 32'(bus.frame_done), 1);
      chk("frame_rdy_end", 32'(bus.frame_rdy), 1);
      chk("obs_rdy_end", 32'(bus.obs_rdy), 0);
      step();
      chk("frame_done_pulse", 32'(bus.frame_done), 0);
    end else begin
      chk("obs_rdy", 32'(bus.obs_rdy), 1);
      chk("frame_done_mid", 32'(bus.frame_done), 0);
      chk("frame_rdy_mid", 32'(bus.frame_rdy), 0);
    end
  endtask

  task automatic run_frame(input int n, input logic [3:0] nw, input logic [3:0][RL-1:0] ids);
    int r;
    chk("frame_rdy_idle", 32'(bus.frame_rdy), 1);
    bus.frame_val = 1'b1;
    bus.obs_num   = OD'(n);
    step();
    bus.frame_val = 1'b0;
    bus.obs_num   = OD'($urandom);
    chk("frame_rdy_busy", 32'(bus.frame_rdy), 0);
    run_stage(PRD, lk);
    end_of_item(n);
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 2));
      for (int j = 0; j < r; j++) begin
        bus.frame_val = 1'b1;
        step();
        chk("obs_rdy_idle", 32'(bus.obs_rdy), 1);
        chk("frame_rdy_obs", 32'(bus.frame_rdy), 0);
      end
      bus.frame_val = 1'b0;
      bus.obs_val   = 1'b1;
      bus.obs_new   = nw[i];
      bus.obs_id    = ids[i];
      step();
      bus.obs_val = 1'b0;
      bus.obs_id  = RL'($urandom);
      if (nw[i] && lm < LM) begin
        lk = lm;
        run_stage(NEW, lk);
        lm++;
        chk("landmark_num_new", 32'(bus.landmark_num), lm);
      end else if (!nw[i] && int'(ids[i]) < lm) begin
        lk = int'(ids[i]);
        run_stage(UPD, lk);
        chk("landmark_num_upd", 32'(bus.landmark_num), lm);
      end else begin
        chk("err_full", 32'(bus.err_full), 32'(nw[i]));
        chk("err_id", 32'(!nw[i]), 32'(bus.err_id));
        chk("no_stage", 32'(bus.stage_val), 0);
      end
      end_of_item(n - 1 - i);
    end
    chk("landmark_num_end", 32'(bus.landmark_num), lm);
  endtask

  initial begin
    logic [3:0]         nw;
    logic [3:0][RL-1:0] ids;
    int                 n;

    bus.frame_val       = 1'b0;
    bus.obs_num         = '0;
    bus.obs_val         = 1'b0;
    bus.obs_new         = 1'b0;
    bus.obs_id          = '0;
    bus.stage_rdy       = 3'b000;
    bus.nonlinear_m_val = 3'b000;
    bus.nonlinear_m_rdy = 3'b000;
    bus.nl_ack          = 1'b0;

    step();
    do_reset();

    // empty frame: predict only
    run_frame(0, 4'b0000, '0);
    chk("empty_frame_lm", 32'(bus.landmark_num), 0);

    // two new landmarks
    run_frame(2, 4'b0011, '0);
    chk("two_new_lm", 32'(bus.landmark_num), 2);

    // valid update id=1, then out-of-range id=5
    ids = '0;
    ids[0] = RL'(1);
    ids[1] = RL'(5);
    run_frame(2, 4'b0000, ids);

    // map full: new landmark rejected
    run_frame(1, 4'b0001, '0);
    chk("full_lm", 32'(bus.landmark_num), 2);

    // reset while waiting on the nonlinear unit during an update
    chk("rst_frame_rdy", 32'(bus.frame_rdy), 1);
    bus.frame_val = 1'b1;
    bus.obs_num   = OD'(1);
    step();
    bus.frame_val = 1'b0;
    run_stage(PRD, lk);
    end_of_item(1);
    bus.obs_val = 1'b1;
    bus.obs_new = 1'b0;
    bus.obs_id  = RL'(1);
    step();
    bus.obs_val = 1'b0;
    chk("rst_upd_stage", 32'(bus.stage_val), 32'(UPD));
    bus.stage_rdy = UPD;
    step();
    bus.stage_rdy       = 3'b000;
    bus.nonlinear_m_val = UPD;
    step();
    bus.nonlinear_m_val = 3'b000;
    chk("rst_nl_req", 32'(bus.nl_req), 1);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    lm = 0;
    lk = 0;
    chk_idle_outputs("midrst");
    bus.nl_ack = 1'b1;
    step();
    bus.nl_ack = 1'b0;
    chk("late_ack_s_val", 32'(bus.nonlinear_s_val), 0);
    chk("late_ack_frame_rdy", 32'(bus.frame_rdy), 1);
    step();
    chk("late_ack_s_val2", 32'(bus.nonlinear_s_val), 0);

    // randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      n  = int'($urandom_range(0, 3));
      nw = 4'($urandom);
      for (int i = 0; i < 4; i++) ids[i] = RL'($urandom_range(0, 3));
      run_frame(n, nw, ids);
      if ($urandom_range(0, 5) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
